// File: rtl/macc_engine_if.sv
// Host-side bus of macc_engine: per-matrix streaming ports plus compute control/status.
interface macc_engine_if #(
    parameter int DATA_W = 32
);
    logic [2:0]        wen;
    logic [2:0]        ren;
    logic [DATA_W-1:0] matrix_a_in;
    logic [DATA_W-1:0] matrix_b_in;
    logic [DATA_W-1:0] matrix_c_in;
    logic [DATA_W-1:0] matrix_a_out;
    logic [DATA_W-1:0] matrix_b_out;
    logic [DATA_W-1:0] matrix_c_out;
    logic              start;
    logic              accumulate;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output wen, ren, matrix_a_in, matrix_b_in, matrix_c_in, start, accumulate,
        input  matrix_a_out, matrix_b_out, matrix_c_out, busy, done, err
    );

    modport slave (
        input  wen, ren, matrix_a_in, matrix_b_in, matrix_c_in, start, accumulate,
        output matrix_a_out, matrix_b_out, matrix_c_out, busy, done, err
    );
endinterface

// File: rtl/macc_engine.sv
// DIM x DIM matrix buffers A/B/C with streaming host ports and a sequential MAC computing C = [C +] A*B.
// Optional build macro MACC_SAT_EN clamps each result to the signed DATA_W range instead of wrapping.
module macc_engine #(
    parameter int DATA_W = 32,
    parameter int DIM    = 4
) (
    input  logic          clk,
    input  logic          rst,
    macc_engine_if.slave  bus
);
    localparam int ACC_W = 2 * DATA_W + $clog2(DIM) + 1;
    localparam int NE    = DIM * DIM;
    localparam int AW    = $clog2(NE);
    localparam int IW    = $clog2(DIM);

    typedef enum logic [1:0] {IDLE, INIT, MAC, DONE} state_t;
    state_t state, state_next;

    // Matrix slot 0 = C, 1 = B, 2 = A, matching the wen/ren bit order.
    logic [DATA_W-1:0] mem [3][NE];
    logic [AW-1:0]     wp  [3];
    logic [AW-1:0]     rp  [3];
    logic [DATA_W-1:0] rd  [3];
    logic [DATA_W-1:0] din [3];

    logic [IW-1:0]             i, j, k;
    logic [AW-1:0]             a_idx, b_idx, c_idx;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc, acc_sum;
    logic [DATA_W-1:0]         result;
    logic                      acc_mode, err_q, busy_i, last_k, last_elem;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(NE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign din[0] = bus.matrix_c_in;
    assign din[1] = bus.matrix_b_in;
    assign din[2] = bus.matrix_a_in;

    assign bus.matrix_c_out = rd[0];
    assign bus.matrix_b_out = rd[1];
    assign bus.matrix_a_out = rd[2];

    assign busy_i   = (state == INIT) || (state == MAC);
    assign bus.busy = busy_i;
    assign bus.done = (state == DONE);
    assign bus.err  = err_q;

    assign last_k    = (k == IW'(DIM - 1));
    assign last_elem = last_k && (i == IW'(DIM - 1)) && (j == IW'(DIM - 1));

    always_comb begin
        a_idx   = AW'(32'(i) * 32'(DIM) + 32'(k));
        b_idx   = AW'(32'(k) * 32'(DIM) + 32'(j));
        c_idx   = AW'(32'(i) * 32'(DIM) + 32'(j));
        prod    = $signed(mem[2][a_idx]) * $signed(mem[1][b_idx]);
        acc_sum = acc + ACC_W'(prod);
    end

`ifdef MACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (acc_sum > SAT_MAX)
            result = SAT_MAX[DATA_W-1:0];
        else if (acc_sum < SAT_MIN)
            result = SAT_MIN[DATA_W-1:0];
        else
            result = acc_sum[DATA_W-1:0];
    end
`else
    always_comb begin
        result = acc_sum[DATA_W-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = INIT;
            INIT: state_next = MAC;
            MAC:  if (last_k) state_next = last_elem ? DONE : INIT;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned m = 0; m < 3; m++) begin
                for (int unsigned e = 0; e < NE; e++)
                    mem[m][e] <= '0;
                wp[m] <= '0;
                rp[m] <= '0;
                rd[m] <= '0;
            end
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            acc_mode <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Reads see pre-write contents; start then overrides the pointer updates.
                    for (int unsigned m = 0; m < 3; m++) begin
                        if (bus.wen[m]) begin
                            mem[m][wp[m]] <= din[m];
                            wp[m]         <= bump(wp[m]);
                        end
                        if (bus.ren[m]) begin
                            rd[m] <= mem[m][rp[m]];
                            rp[m] <= bump(rp[m]);
                        end
                    end
                    if (bus.start) begin
                        for (int unsigned m = 0; m < 3; m++) begin
                            wp[m] <= '0;
                            rp[m] <= '0;
                        end
                        i        <= '0;
                        j        <= '0;
                        acc_mode <= bus.accumulate;
                        err_q    <= 1'b0;
                    end
                end
                INIT: begin
                    acc <= acc_mode ? ACC_W'($signed(mem[0][c_idx])) : '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= acc_sum;
                    if (last_k) begin
                        k             <= '0;
                        mem[0][c_idx] <= result;
                        if (j == IW'(DIM - 1)) begin
                            j <= '0;
                            i <= i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
            if (busy_i && ((|bus.wen) || (|bus.ren)))
                err_q <= 1'b1;
        end
    end
endmodule
